vga_text_renderer: RTL and testbench
====================================

# vga_text_renderer

Parametrised text-mode VGA renderer that generalises the stack calculator's display path. It owns its own sync timing and an internal character buffer of 4-bit calculator codes written through a simple write port. It draws each code through `font_rom` with a fully pipelined, sync-aligned datapath. It adds programmable foreground/background colours and a blinking, inverting cursor, and drives the board VGA pins directly.

## Interface
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal porch and sync widths, in pixels.
- `V_ACTIVE`, 480: visible lines.
- `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33: vertical porch and sync widths, in lines.
- `COLS`, `H_ACTIVE/8`: text columns. Glyph width is fixed at 8.
- `ROWS`, `V_ACTIVE/16`: text rows. Glyph height is fixed at 16.
- `BLINK_FRAMES`, 30: frames per cursor blink half-period (≥1).
- `ADDR_W`, `$clog2(COLS*ROWS)`: cell address width.
- `clk` in 1: pixel clock, one pixel per cycle.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_en` in 1: write strobe for the character buffer.
- `wr_addr` in `ADDR_W`: cell index, computed as row*COLS + col.
- `wr_data` in 4: calculator code.
- `fg_color` in 12: foreground RGB444.
- `bg_color` in 12: background RGB444.
- `cursor_en` in 1: enables the cursor.
- `cursor_addr` in `ADDR_W`: cell index of the cursor.
- `frame_start` out 1: one-cycle pulse at the first cycle of pixel (0,0), aligned with the pins.
- `vga_h_sync`, `vga_v_sync` out 1: syncs, active low.
- `vga_R`, `vga_G`, `vga_B` out 4: colour outputs.

## Operation
- **Stage 0 (counters):**
  - `hcnt` runs 0..H_total-1, where H_total = sum of the four horizontal parameters (800 at defaults).
  - `vcnt` increments when `hcnt` wraps and itself wraps at V_total (525 at defaults).
  - Active area is `hcnt<H_ACTIVE && vcnt<V_ACTIVE`.
  - Sync is low while the counter is in [ACTIVE+FP, ACTIVE+FP+SYNC).
- **Stage 1 (buffer read):**
  - Cell index = (vcnt>>4)*COLS + (hcnt>>3), read synchronously from a COLS*ROWS×4 dual-port RAM.
  - `row_addr = vcnt[3:0]` and `bit_addr = hcnt[2:0]` are carried forward through the pipeline.
- **Stage 2 (font ROM):**
  - Code map: 0–9 → 0x30–0x39; A → 0x2B '+'; B → 0x2D '-'; C → 0x2A '*'; D → 0x2F '/'; E → 0x3D '='; F → 0x00 blank.
  - ROM address = {char_addr[5:0], row_addr}. The ROM has 1-cycle read latency.
- **Stage 3 (colour):**
  - `pix = font_word[7-bit_addr]`.
  - On a cursor cell with `cursor_en=1` and blink phase 1, `pix` is inverted.
  - rgb = `pix ? fg_color : bg_color`. Outside the active area, rgb = 0x000.
  - All outputs are registered.
- **Buffer writes:**
  - `wr_en=1` with `wr_addr < COLS*ROWS` writes `wr_data` on the clock edge. Out-of-range writes are ignored.
  - Writes are independent of raster position.
  - A write and a read of the same cell in the same cycle returns the old data; the new value appears from the next read.
- **Blink:**
  - A frame counter counts 0..BLINK_FRAMES-1, advancing on each `frame_start`.
  - On wrap the counter toggles `blink_phase`.
  - The counter and `blink_phase` reset to 0, so the cursor is not shown until the first toggle.
- `fg_color`, `bg_color`, `cursor_en` and `cursor_addr` are sampled at stage 3. Cursor match is done on the stage-1 cell index carried forward, never on the live input.

## Timing
- Pixel latency: counters to pins is 3 cycles.
- `vga_h_sync`, `vga_v_sync`, the active flag and `frame_start` are delayed by 3 register stages so they stay aligned with colour.
- Reset (asynchronous, while `rst_n=0`):
  - Counters = 0, all pipeline registers cleared.
  - Syncs = 1, rgb = 0x000, `frame_start` = 0.
- Reset deassertion:
  - `hcnt`/`vcnt` start at 0 on the first rising edge with `rst_n=1`.
  - The first `frame_start` appears 3 cycles later.
- Character buffer contents are not reset. The bench must initialise cells before checking glyphs.
- Reset asserted mid-line takes effect immediately. The raster restarts at (0,0), and the blink state is cleared.
- Line period = 800 cycles; frame period = 420000 cycles (defaults).
- `frame_start` period equals the frame period exactly.

## Test plan
- **Sync timing:** after reset, `frame_start` appears at cycle 3.
  - `vga_h_sync` goes low at cycles 3+656..3+751 of each line.
  - `vga_v_sync` goes low for lines 490–491.
- **Glyph:** write code 0x1 at cell 0 and 0xF everywhere else.
  - Row 0 pixels match the `font_rom` 0x31 glyph in `fg_color`/`bg_color`.
  - The pixel at column 8 equals `bg_color`.
- **Operator map:** write codes A–E at cells 81–85 (row 1, columns 1–5).
  - The rendered ROM addresses correspond to 0x2B, 0x2D, 0x2A, 0x2F, 0x3D.
- **Cursor:** `cursor_en=1`, `cursor_addr=0`, `BLINK_FRAMES=1`.
  - Frame 0: cell 0 is normal.
  - Frame 1: cell 0 is inverted, with `fg_color`/`bg_color` swapped per pixel.
  - Frame 2: cell 0 is normal.
  - All other cells are never inverted.
- **Write edge cases:**
  - Write to address COLS*ROWS: no visible change anywhere.
  - Write to cell 0 while cell 0 is being read: the old glyph is shown in that line; the new glyph is shown from the next read.
- **Reset mid-frame:** assert `rst_n=0` at line 200.
  - Outputs go to reset values within the same cycle.
  - After release, `frame_start` appears 3 cycles later and the blink phase is back to 0.

Source files
------------

// File: rtl/vga_text_renderer_if.sv
// rtl/vga_text_renderer_if.sv - host-side port of the text renderer
// Buffer write port plus colour and cursor controls.
interface vga_text_renderer_if #(
  parameter int ADDR_W = 12
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        wr_data;
  logic [11:0]       fg_color;
  logic [11:0]       bg_color;
  logic              cursor_en;
  logic [ADDR_W-1:0] cursor_addr;

  modport master (
    output wr_en, wr_addr, wr_data, fg_color, bg_color, cursor_en, cursor_addr
  );

  modport slave (
    input wr_en, wr_addr, wr_data, fg_color, bg_color, cursor_en, cursor_addr
  );
endinterface

// File: rtl/vga_text_renderer.sv
// rtl/vga_text_renderer.sv - text-mode VGA renderer for calculator codes
// Raster counters, character RAM, font ROM and colour stage; 3-cycle pipeline.
module vga_text_renderer #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int COLS         = H_ACTIVE / 8,
  parameter int ROWS         = V_ACTIVE / 16,
  parameter int BLINK_FRAMES = 30,
  parameter int ADDR_W       = $clog2(COLS * ROWS)
) (
  input  logic                clk,
  input  logic                rst_n,
  vga_text_renderer_if.slave  host,
  output logic                frame_start,
  output logic                vga_h_sync,
  output logic                vga_v_sync,
  output logic [3:0]          vga_R,
  output logic [3:0]          vga_G,
  output logic [3:0]          vga_B
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CELLS   = COLS * ROWS;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  function automatic logic [5:0] char_map(input logic [3:0] code);
    case (code)
      4'hA:    char_map = 6'h2B;
      4'hB:    char_map = 6'h2D;
      4'hC:    char_map = 6'h2A;
      4'hD:    char_map = 6'h2F;
      4'hE:    char_map = 6'h3D;
      4'hF:    char_map = 6'h00;
      default: char_map = {2'b11, code};
    endcase
  endfunction

  // Row 0 of each glyph sits in the most significant byte.
  function automatic logic [127:0] font_glyph(input logic [5:0] ch);
    case (ch)
      6'h2A:   font_glyph = 128'h00000000_663CFF3C_66000000_00000000;
      6'h2B:   font_glyph = 128'h00000000_181818FF_18181800_00000000;
      6'h2D:   font_glyph = 128'h00000000_0000007E_00000000_00000000;
      6'h2F:   font_glyph = 128'h00000206_0C183060_C0800000_00000000;
      6'h30:   font_glyph = 128'h00003C66_666E7666_6666663C_00000000;
      6'h31:   font_glyph = 128'h00001838_78181818_1818187E_00000000;
      6'h32:   font_glyph = 128'h00003C66_06060C18_3060667E_00000000;
      6'h33:   font_glyph = 128'h00003C66_06061C06_0606663C_00000000;
      6'h34:   font_glyph = 128'h00000C1C_3C6CCCFE_0C0C0C1E_00000000;
      6'h35:   font_glyph = 128'h00007E60_60607C06_0606663C_00000000;
      6'h36:   font_glyph = 128'h00001C30_60607C66_6666663C_00000000;
      6'h37:   font_glyph = 128'h00007E66_06060C18_30303030_00000000;
      6'h38:   font_glyph = 128'h00003C66_66663C66_6666663C_00000000;
      6'h39:   font_glyph = 128'h00003C66_66663E06_06060C38_00000000;
      6'h3D:   font_glyph = 128'h00000000_0000FEFE_00FEFE00_00000000;
      default: font_glyph = 128'h0;
    endcase
  endfunction

  function automatic logic [7:0] font_rom(input logic [9:0] addr);
    logic [127:0] g;
    g = font_glyph(addr[9:4]);
    font_rom = g[8 * (15 - int'(addr[3:0])) +: 8];
  endfunction

  logic [HW-1:0]     hcnt;
  logic [VW-1:0]     vcnt;
  logic [3:0]        mem [CELLS];

  logic              active0, hs0, vs0, fs0, frame_end0;
  logic [ADDR_W-1:0] cell0;

  always_comb begin
    active0    = (int'(hcnt) < H_ACTIVE) && (int'(vcnt) < V_ACTIVE);
    hs0        = !((int'(hcnt) >= H_ACTIVE + H_FP) && (int'(hcnt) < H_ACTIVE + H_FP + H_SYNC));
    vs0        = !((int'(vcnt) >= V_ACTIVE + V_FP) && (int'(vcnt) < V_ACTIVE + V_FP + V_SYNC));
    fs0        = (hcnt == '0) && (vcnt == '0);
    frame_end0 = (int'(hcnt) == H_TOTAL - 1) && (int'(vcnt) == V_TOTAL - 1);
    cell0      = ADDR_W'(int'(vcnt >> 4) * COLS + int'(hcnt >> 3));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (int'(hcnt) == H_TOTAL - 1) begin
      hcnt <= '0;
      vcnt <= (int'(vcnt) == V_TOTAL - 1) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  // Buffer contents survive reset; writes are accepted even while in reset.
  always_ff @(posedge clk) begin
    if (host.wr_en && int'(host.wr_addr) < CELLS)
      mem[host.wr_addr] <= host.wr_data;
  end

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  // Counting completed frames keeps frame 0 un-inverted after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end0) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  logic [3:0]        code1, row1;
  logic [2:0]        bit1, bit2;
  logic [ADDR_W-1:0] cell1, cell2;
  logic              active1, hs1, vs1, fs1;
  logic              active2, hs2, vs2, fs2;
  logic [7:0]        font_q;
  logic [11:0]       rgb_q;
  logic              pix;

  always_comb begin
    pix = font_q[3'd7 - bit2];
    if (host.cursor_en && blink_phase && (cell2 == host.cursor_addr))
      pix = ~pix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code1       <= 4'h0;
      row1        <= 4'h0;
      bit1        <= 3'h0;
      cell1       <= '0;
      active1     <= 1'b0;
      hs1         <= 1'b1;
      vs1         <= 1'b1;
      fs1         <= 1'b0;
      font_q      <= 8'h0;
      bit2        <= 3'h0;
      cell2       <= '0;
      active2     <= 1'b0;
      hs2         <= 1'b1;
      vs2         <= 1'b1;
      fs2         <= 1'b0;
      rgb_q       <= 12'h000;
      vga_h_sync  <= 1'b1;
      vga_v_sync  <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      code1       <= active0 ? mem[cell0] : 4'hF;
      row1        <= vcnt[3:0];
      bit1        <= hcnt[2:0];
      cell1       <= cell0;
      active1     <= active0;
      hs1         <= hs0;
      vs1         <= vs0;
      fs1         <= fs0;

      font_q      <= font_rom({char_map(code1), row1});
      bit2        <= bit1;
      cell2       <= cell1;
      active2     <= active1;
      hs2         <= hs1;
      vs2         <= vs1;
      fs2         <= fs1;

      rgb_q       <= active2 ? (pix ? host.fg_color : host.bg_color) : 12'h000;
      vga_h_sync  <= hs2;
      vga_v_sync  <= vs2;
      frame_start <= fs2;
    end
  end

  assign vga_R = rgb_q[11:8];
  assign vga_G = rgb_q[7:4];
  assign vga_B = rgb_q[3:0];
endmodule

// File: tb/tb_vga_text_renderer.sv
// tb/tb_vga_text_renderer.sv - scoreboard bench for vga_text_renderer
// Small raster geometry so several frames fit in a short run.
module tb_vga_text_renderer;
  localparam int HA = 160, HF = 8, HS = 16, HB = 8;
  localparam int VA = 32, VF = 2, VS = 2, VB = 4;
  localparam int HT    = HA + HF + HS + HB;
  localparam int VT    = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int COLS  = HA / 8;
  localparam int CELLS = COLS * (VA / 16);
  localparam int AW    = $clog2(CELLS);
  localparam logic [11:0] FG = 12'hABC;
  localparam logic [11:0] BG = 12'h123;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start, vga_h_sync, vga_v_sync;
  logic [3:0] vga_R, vga_G, vga_B;

  vga_text_renderer_if #(.ADDR_W(AW)) host ();

  vga_text_renderer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .BLINK_FRAMES(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host       (host),
    .frame_start(frame_start),
    .vga_h_sync (vga_h_sync),
    .vga_v_sync (vga_v_sync),
    .vga_R      (vga_R),
    .vga_G      (vga_G),
    .vga_B      (vga_B)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          pix;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fs;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mon_p;

  // Edges since reset release; pins show pixel cyc-3.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst_n && cyc >= 3) begin
      mon_p = cyc - 3;
      while (sbq.size() > 0 && sbq[0].pix <= mon_p) begin
        mon_e = sbq.pop_front();
        checks++;
        if (mon_e.pix != mon_p) begin
          errors++;
          $display("FAIL %s: pixel %0d not sampled (now at %0d)", mon_e.tag, mon_e.pix, mon_p);
        end else if ({vga_R, vga_G, vga_B} !== mon_e.rgb || vga_h_sync !== mon_e.hs ||
                     vga_v_sync !== mon_e.vs || frame_start !== mon_e.fs) begin
          errors++;
          $display("FAIL %s: pix %0d got rgb=%h hs=%b vs=%b fs=%b, expected rgb=%h hs=%b vs=%b fs=%b",
                   mon_e.tag, mon_p, {vga_R, vga_G, vga_B}, vga_h_sync, vga_v_sync, frame_start,
                   mon_e.rgb, mon_e.hs, mon_e.vs, mon_e.fs);
        end
      end
    end
  end

  task automatic push(input int pix, input logic [11:0] rgb, input logic hs, input logic vs,
                      input logic fs, input string tag);
    exp_t e;
    e.pix = pix; e.rgb = rgb; e.hs = hs; e.vs = vs; e.fs = fs; e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic push_row(input int frame, input int y, input int x0, input logic [7:0] bits,
                          input logic inv, input string tag);
    for (int i = 0; i < 8; i++)
      push(frame * FRAME + y * HT + x0 + i, (bits[7 - i] ^ inv) ? FG : BG, 1'b1, 1'b1, 1'b0, tag);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input int addr, input logic [3:0] data);
    host.wr_en   = 1'b1;
    host.wr_addr = AW'(addr);
    host.wr_data = data;
    @(negedge clk);
    host.wr_en   = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2 * FRAME && sbq.size() > 0; i++) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expectations never reached", tag, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    host.wr_en       = 1'b0;
    host.wr_addr     = '0;
    host.wr_data     = 4'h0;
    host.fg_color    = FG;
    host.bg_color    = BG;
    host.cursor_en   = 1'b1;
    host.cursor_addr = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({vga_h_sync, vga_v_sync, frame_start, vga_R, vga_G, vga_B}),
        32'({1'b1, 1'b1, 1'b0, 12'h000}));

    for (int i = 0; i < CELLS; i++) wr(i, (i == 0) ? 4'h1 : 4'hF);
    for (int k = 0; k < 5; k++) wr(COLS + 1 + k, 4'(4'hA + k));
    wr(CELLS, 4'h8);
    rst_n = 1'b1;

    // Frame 0: sync timing, glyph '1', operators; blink phase 0.
    push(0, BG, 1'b1, 1'b1, 1'b1, "frame_start_first");
    push(1, BG, 1'b1, 1'b1, 1'b0, "frame_start_pulse");
    push(160, 12'h000, 1'b1, 1'b1, 1'b0, "blank_rgb");
    push(167, 12'h000, 1'b1, 1'b1, 1'b0, "hs_before");
    push(168, 12'h000, 1'b0, 1'b1, 1'b0, "hs_first");
    push(183, 12'h000, 1'b0, 1'b1, 1'b0, "hs_last");
    push(184, 12'h000, 1'b1, 1'b1, 1'b0, "hs_after");
    push_row(0, 5, 0, 8'h18, 1'b0, "glyph_one_row5");
    push(5 * HT + 8, BG, 1'b1, 1'b1, 1'b0, "col8_bg");
    push(5 * HT + 64, BG, 1'b1, 1'b1, 1'b0, "oob_write_no_effect");
    push_row(0, 23, 8, 8'hFF, 1'b0, "op_plus");
    push_row(0, 23, 16, 8'h7E, 1'b0, "op_minus");
    push_row(0, 23, 24, 8'h3C, 1'b0, "op_mul");
    push_row(0, 23, 32, 8'h60, 1'b0, "op_div");
    push_row(0, 23, 40, 8'hFE, 1'b0, "op_eq");
    push(33 * HT, 12'h000, 1'b1, 1'b1, 1'b0, "vs_before");
    push(34 * HT, 12'h000, 1'b1, 1'b0, 1'b0, "vs_first");
    push(35 * HT, 12'h000, 1'b1, 1'b0, 1'b0, "vs_last");
    push(36 * HT, 12'h000, 1'b1, 1'b1, 1'b0, "vs_after");
    // Frame 1: cursor cell inverted, neighbour untouched.
    push(FRAME, FG, 1'b1, 1'b1, 1'b1, "frame_start_period");
    push_row(1, 5, 0, 8'h18, 1'b1, "cursor_inverted");
    push(FRAME + 5 * HT + 8, BG, 1'b1, 1'b1, 1'b0, "cursor_neighbour");
    // Frame 2: cursor normal again; cell 0 rewritten during its read in line 6.
    push_row(2, 5, 0, 8'h18, 1'b0, "cursor_restored");
    push_row(2, 6, 0, 8'h18, 1'b0, "write_old_glyph");
    push_row(2, 8, 0, 8'h30, 1'b0, "write_new_glyph");

    wait_cyc(2 * FRAME + 6 * HT + 7);
    wr(0, 4'h7);
    drain("frame0_2");

    wait_cyc(3 * FRAME + 23 * HT + 8 + 3);
    chk("pre_reset_rgb", 32'({vga_R, vga_G, vga_B}), 32'(FG));
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", 32'({vga_h_sync, vga_v_sync, frame_start, vga_R, vga_G, vga_B}),
        32'({1'b1, 1'b1, 1'b0, 12'h000}));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push(0, BG, 1'b1, 1'b1, 1'b1, "restart_frame_start");
    push(1, BG, 1'b1, 1'b1, 1'b0, "restart_pulse_end");
    push_row(0, 5, 0, 8'h06, 1'b0, "blink_cleared");
    drain("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
